trace_stream_arbiter: RTL and testbench

- Shares one cpu_checker character port among NSRC independent trace sources, each producing "^time@pc: ... <= data#" records.
- Buffers each source in its own FIFO and grants the checker only to a source holding a complete record (terminated by '#'), so records reach the checker contiguously and never interleave.
- Captures the checker's format_type/error_code for each record and tags the result with its source id.

---
 rtl/trace_stream_arbiter.sv | 166 ++++++++++++++++
 tb/tb_trace_stream_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_stream_arbiter.sv
// Shares one checker character port among NSRC buffered trace sources, granting whole records only.
// Define TRACE_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module trace_stream_arbiter #(
    parameter int unsigned NSRC      = 4,
    parameter int unsigned DEPTH     = 64,
    parameter logic [7:0]  IDLE_CHAR = 8'h00
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NSRC-1:0]          src_valid,
    input  logic [8*NSRC-1:0]        src_char,
    output logic [NSRC-1:0]          src_ready,
    output logic [7:0]               chk_char,
    input  logic [1:0]               chk_format_type,
    input  logic [3:0]               chk_error_code,
    output logic                     res_valid,
    output logic [$clog2(NSRC)-1:0]  res_src,
    output logic [1:0]               res_format,
    output logic [3:0]               res_error,
    output logic [NSRC-1:0]          ovf,
    output logic                     busy
);

    localparam int unsigned SW = $clog2(NSRC);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [7:0]  HASH = 8'h23;

    typedef enum logic [1:0] {StIdle, StStream, StHold, StCapture} state_e;

    state_e          state_q;
    logic [SW-1:0]   grant_q;
`ifndef TRACE_ARB_FIXED_PRIO_EN
    logic [SW-1:0]   ptr_q;
`endif

    logic [7:0]      mem_q  [NSRC][DEPTH];
    logic [PW-1:0]   wptr_q [NSRC];
    logic [PW-1:0]   rptr_q [NSRC];
    logic [PW:0]     cnt_q  [NSRC];
    logic [PW:0]     rcnt_q [NSRC];

    logic [NSRC-1:0] full, elig, wr, pop, flush;
    logic [7:0]      head [NSRC];
    logic            any_elig;
    logic [SW-1:0]   pick;
    logic [7:0]      pop_char;

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            full[i]  = (cnt_q[i] == (PW+1)'(DEPTH));
            elig[i]  = (rcnt_q[i] != '0);
            wr[i]    = src_valid[i] && !full[i];
            // A full FIFO without a terminator can never drain, so it is dropped.
            flush[i] = full[i] && !elig[i];
            head[i]  = mem_q[i][rptr_q[i]];
        end
    end

    assign src_ready = ~full;
    assign busy      = (state_q != StIdle);

    always_comb begin
        any_elig = |elig;
        pick     = '0;
`ifdef TRACE_ARB_FIXED_PRIO_EN
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (elig[i]) pick = SW'(i);
        end
`else
        // Scan downward so the first eligible source after the pointer wins.
        for (int k = NSRC; k >= 1; k--) begin
            logic [SW-1:0] idx;
            idx = SW'((int'(ptr_q) + k) % int'(NSRC));
            if (elig[idx]) pick = idx;
        end
`endif
    end

    always_comb begin
        pop = '0;
        if (state_q == StIdle && any_elig) pop[pick] = 1'b1;
        else if (state_q == StStream)      pop[grant_q] = 1'b1;
        pop_char = (state_q == StIdle) ? head[pick] : head[grant_q];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NSRC; i++) begin
            if (wr[i]) mem_q[i][wptr_q[i]] <= src_char[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NSRC; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
                rcnt_q[i] <= '0;
            end
            ovf <= '0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (flush[i]) begin
                    rptr_q[i] <= wptr_q[i];
                    cnt_q[i]  <= '0;
                    ovf[i]    <= 1'b1;
                end else begin
                    if (wr[i])  wptr_q[i] <= wptr_q[i] + 1'b1;
                    if (pop[i]) rptr_q[i] <= rptr_q[i] + 1'b1;
                    cnt_q[i] <= cnt_q[i] + (PW+1)'(wr[i]) - (PW+1)'(pop[i]);
                end
                rcnt_q[i] <= rcnt_q[i]
                           + (PW+1)'(wr[i] && (src_char[8*i +: 8] == HASH))
                           - (PW+1)'(pop[i] && (head[i] == HASH));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            grant_q    <= '0;
`ifndef TRACE_ARB_FIXED_PRIO_EN
            ptr_q      <= SW'(NSRC - 1);
`endif
            chk_char   <= IDLE_CHAR;
            res_valid  <= 1'b0;
            res_src    <= '0;
            res_format <= '0;
            res_error  <= '0;
        end else begin
            res_valid <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (any_elig) begin
                        grant_q  <= pick;
`ifndef TRACE_ARB_FIXED_PRIO_EN
                        ptr_q    <= pick;
`endif
                        chk_char <= pop_char;
                        state_q  <= (pop_char == HASH) ? StHold : StStream;
                    end else begin
                        chk_char <= IDLE_CHAR;
                    end
                end
                StStream: begin
                    chk_char <= pop_char;
                    if (pop_char == HASH) state_q <= StHold;
                end
                StHold: begin
                    chk_char <= IDLE_CHAR;
                    state_q  <= StCapture;
                end
                StCapture: begin
                    res_src    <= grant_q;
                    res_format <= chk_format_type;
                    res_error  <= chk_error_code;
                    res_valid  <= 1'b1;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_trace_stream_arbiter.sv
// Bench for trace_stream_arbiter: queue-based reference model, grant-order table and directed corners.
module tb_trace_stream_arbiter;
    localparam int N  = 4;
    localparam int D  = 64;
    localparam int DS = 8;
    localparam logic [7:0] IDLE = 8'h00;
    localparam logic [7:0] HASH = 8'h23;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic [N-1:0]   vvalid;
    logic [7:0]     vchar [N];
    logic [8*N-1:0] src_char_bus;
    logic [N-1:0]   src_ready;
    logic [7:0]     chk_char;
    logic [1:0]     fmt_in;
    logic [3:0]     err_in;
    logic           res_valid;
    logic [1:0]     res_src;
    logic [1:0]     res_format;
    logic [3:0]     res_error;
    logic [N-1:0]   ovf;
    logic           busy;

    logic [N-1:0]   s_valid;
    logic [7:0]     s_chari [N];
    logic [8*N-1:0] s_char_bus;
    logic [N-1:0]   s_ready;
    logic [7:0]     s_chk;
    logic           s_rv;
    logic [1:0]     s_src;
    logic [1:0]     s_fmt;
    logic [3:0]     s_err;
    logic [N-1:0]   s_ovf;
    logic           s_busy;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            src_char_bus[8*i +: 8] = vchar[i];
            s_char_bus[8*i +: 8]   = s_chari[i];
        end
    end

    trace_stream_arbiter #(.NSRC(N), .DEPTH(D), .IDLE_CHAR(IDLE)) dut (
        .clk(clk), .reset(reset), .src_valid(vvalid), .src_char(src_char_bus),
        .src_ready(src_ready), .chk_char(chk_char), .chk_format_type(fmt_in),
        .chk_error_code(err_in), .res_valid(res_valid), .res_src(res_src),
        .res_format(res_format), .res_error(res_error), .ovf(ovf), .busy(busy)
    );

    trace_stream_arbiter #(.NSRC(N), .DEPTH(DS), .IDLE_CHAR(IDLE)) dut_small (
        .clk(clk), .reset(reset), .src_valid(s_valid), .src_char(s_char_bus),
        .src_ready(s_ready), .chk_char(s_chk), .chk_format_type(2'd0),
        .chk_error_code(4'd0), .res_valid(s_rv), .res_src(s_src),
        .res_format(s_fmt), .res_error(s_err), .ovf(s_ovf), .busy(s_busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each FIFO is a plain queue; a granted record of L chars is shown
    // for L cycles, then two idle cycles, with the result pulse in the second.
    typedef logic [7:0] cq_t [$];
    cq_t          mq [N];
    cq_t          gen [N];
    int           m_rr, m_tick, m_rem, m_cur;
    logic [N-1:0] m_ovf;
    bit           m_init = 0;
    logic [7:0]   e_chk;
    logic         e_rv, e_busy;
    int           e_src;
    logic [1:0]   e_fmt;
    logic [3:0]   e_err;
    int           grant_log [$];

    task automatic model_reset();
        for (int i = 0; i < N; i++) mq[i].delete();
        m_rr = N - 1; m_tick = 0; m_rem = 0; m_cur = 0; m_ovf = '0;
        e_chk = IDLE; e_rv = 0; e_busy = 0; m_init = 1;
    endtask

    task automatic model_step();
        int hc [N];
        bit full [N];
        int g;
        if (reset) begin
            model_reset();
            return;
        end
        for (int i = 0; i < N; i++) begin
            hc[i] = 0;
            for (int j = 0; j < mq[i].size(); j++) if (mq[i][j] == HASH) hc[i]++;
            full[i] = (mq[i].size() >= D);
        end
        e_rv = 0;
        if (m_tick > 0) m_tick--;
        if (m_tick == 1) begin
            e_rv = 1; e_src = m_cur; e_fmt = fmt_in; e_err = err_in;
        end
        if (m_tick == 0) begin
            g = -1;
`ifdef TRACE_ARB_FIXED_PRIO_EN
            for (int i = N - 1; i >= 0; i--) if (hc[i] > 0) g = i;
`else
            for (int k = N; k >= 1; k--) if (hc[(m_rr + k) % N] > 0) g = (m_rr + k) % N;
`endif
            if (g >= 0) begin
                m_cur = g; m_rr = g; m_rem = 0;
                while (mq[g][m_rem] != HASH) m_rem++;
                m_rem++;
                m_tick = m_rem + 2;
            end
        end
        if (m_rem > 0) begin
            e_chk = mq[m_cur].pop_front();
            m_rem--;
        end else begin
            e_chk = IDLE;
        end
        for (int i = 0; i < N; i++) begin
            if (full[i] && hc[i] == 0) begin
                mq[i].delete();
                m_ovf[i] = 1'b1;
            end else if (vvalid[i] && !full[i]) begin
                mq[i].push_back(vchar[i]);
            end
        end
        e_busy = (m_tick >= 2);
    endtask

    task automatic cycle();
        if (m_init && !reset)
            for (int i = 0; i < N; i++)
                check($sformatf("ready[%0d]", i), 32'(src_ready[i]), 32'(mq[i].size() < D));
        model_step();
        @(posedge clk);
        #1;
        if (m_init) begin
            check("chk_char", 32'(chk_char), 32'(e_chk));
            check("res_valid", 32'(res_valid), 32'(e_rv));
            if (e_rv) begin
                check("res_src", 32'(res_src), 32'(e_src));
                check("res_format", 32'(res_format), 32'(e_fmt));
                check("res_error", 32'(res_error), 32'(e_err));
            end
            check("ovf", 32'(ovf), 32'(m_ovf));
            check("busy", 32'(busy), 32'(e_busy));
            if (res_valid) grant_log.push_back(int'(res_src));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        grant_log.delete();
    endtask

    task automatic new_rec(input int i);
        string alph;
        int n;
        alph = "0123456789abcdef@:$ <=^";
        if ($urandom_range(0, 7) != 0) gen[i].push_back(8'h5E);
        n = $urandom_range(1, 10);
        for (int k = 0; k < n; k++) gen[i].push_back(alph[$urandom_range(0, alph.len() - 1)]);
        gen[i].push_back(HASH);
    endtask

    task automatic s_collect(output logic [63:0] acc, output int n, output int src);
        int w;
        acc = '0; n = 0; src = -1; w = 0;
        while (s_chk == IDLE && w < 20) begin cycle(); w++; end
        while (s_chk != IDLE && n < 8) begin acc = {acc[55:0], s_chk}; n++; cycle(); end
        w = 0;
        while (!s_rv && w < 5) begin cycle(); w++; end
        if (s_rv) src = int'(s_src);
    endtask

    typedef struct {
        logic [N-1:0] mask;
        int           nrec;
        int           exp_len;
        int           exp [8];
    } rr_vec_t;

    initial begin
        rr_vec_t tbl [4];
        string   rec, part, sab;
        int      w, n, src, seen;
        logic [63:0] acc;
        int      pc [N];

`ifdef TRACE_ARB_FIXED_PRIO_EN
        tbl[0] = '{4'b1011, 2, 6, '{0, 0, 1, 1, 3, 3, 0, 0}};
        tbl[2] = '{4'b1100, 2, 4, '{2, 2, 3, 3, 0, 0, 0, 0}};
`else
        tbl[0] = '{4'b1011, 2, 6, '{0, 1, 3, 0, 1, 3, 0, 0}};
        tbl[2] = '{4'b1100, 2, 4, '{2, 3, 2, 3, 0, 0, 0, 0}};
`endif
        tbl[1] = '{4'b0100, 1, 1, '{2, 0, 0, 0, 0, 0, 0, 0}};
        tbl[3] = '{4'b1111, 1, 4, '{0, 1, 2, 3, 0, 0, 0, 0}};

        reset = 1'b1; vvalid = '0; s_valid = '0; fmt_in = 2'd1; err_in = 4'd2;
        for (int i = 0; i < N; i++) begin vchar[i] = 8'h0; s_chari[i] = 8'h0; end
        cycle();
        cycle();
        reset = 1'b0;

        // Reset state.
        check("rst_res_src", 32'(res_src), 0);
        check("rst_res_format", 32'(res_format), 0);
        check("rst_res_error", 32'(res_error), 0);
        check("rst_ready", 32'(src_ready), 32'hF);
        check("rst_small_ovf", 32'(s_ovf), 0);
        check("rst_small_chk", 32'(s_chk), 32'(IDLE));

        // Single record with a stub checker answering format=1, error=2.
        rec = "^10@00003000: $1 <= 0000000a#";
        for (int k = 0; k < rec.len(); k++) begin
            vvalid[0] = 1'b1; vchar[0] = rec[k];
            cycle();
        end
        vvalid = '0;
        w = 0;
        while (chk_char == IDLE && w < 10) begin cycle(); w++; end
        check("single_grant_latency", w, 1);
        for (int k = 0; k < rec.len(); k++) begin
            check($sformatf("single_char[%0d]", k), 32'(chk_char), 32'(rec[k]));
            cycle();
        end
        check("single_rv_early", 32'(res_valid), 0);
        cycle();
        check("single_rv", 32'(res_valid), 1);
        check("single_src", 32'(res_src), 0);
        check("single_fmt", 32'(res_format), 1);
        check("single_err", 32'(res_error), 2);
        cycle();
        check("single_rv_pulse", 32'(res_valid), 0);

        // Grant-order table: equal-length records written in lockstep on masked sources.
        for (int t = 0; t < 4; t++) begin
            do_reset();
            for (int r = 0; r < tbl[t].nrec; r++) begin
                for (int c = 0; c < 10; c++) begin
                    for (int i = 0; i < N; i++) begin
                        vvalid[i] = tbl[t].mask[i];
                        vchar[i]  = (c == 0) ? 8'h5E : (c == 9) ? HASH : 8'h61 + 8'(i);
                    end
                    cycle();
                end
            end
            vvalid = '0;
            w = 0;
            while (grant_log.size() < tbl[t].exp_len && w < 400) begin cycle(); w++; end
            check($sformatf("rr%0d_count", t), grant_log.size(), tbl[t].exp_len);
            for (int k = 0; k < tbl[t].exp_len; k++)
                check($sformatf("rr%0d_grant[%0d]", t, k),
                      (k < grant_log.size()) ? grant_log[k] : -1, tbl[t].exp[k]);
        end

        // Partial record is held back until its terminator arrives.
        do_reset();
        part = "^5@0000";
        for (int k = 0; k < part.len(); k++) begin
            vvalid[2] = 1'b1; vchar[2] = part[k];
            cycle();
        end
        vvalid = '0;
        for (int k = 0; k < 10; k++) cycle();
        check("partial_idle", 32'(chk_char), 32'(IDLE));
        check("partial_not_busy", 32'(busy), 0);
        vvalid[2] = 1'b1; vchar[2] = HASH;
        cycle();
        vvalid = '0;
        check("partial_hash_edge_idle", 32'(chk_char), 32'(IDLE));
        cycle();
        check("partial_granted", 32'(chk_char), 32'h5E);
        for (int k = 0; k < 12; k++) cycle();
        check("partial_src", (grant_log.size() > 0) ? grant_log[0] : -1, 2);

        // Overflow on the shallow instance: source 1 fills without '#', source 0 keeps a partial.
        do_reset();
        sab = "^ab";
        for (int k = 0; k < DS; k++) begin
            check($sformatf("ovf_ready_before[%0d]", k), 32'(s_ready[1]), 1);
            s_valid[0] = (k < 3); s_chari[0] = (k < 3) ? sab[k] : 8'h0;
            s_valid[1] = 1'b1;    s_chari[1] = 8'h61 + 8'(k);
            cycle();
        end
        s_valid[0] = 1'b0;
        check("ovf_full_ready", 32'(s_ready[1]), 0);
        check("ovf_not_yet", 32'(s_ovf), 0);
        s_chari[1] = 8'h78;
        cycle();
        s_valid[1] = 1'b0;
        check("ovf_flag", 32'(s_ovf), 32'b0010);
        check("ovf_ready_back", 32'(s_ready), 32'hF);
        s_valid[1] = 1'b1; s_chari[1] = HASH;
        cycle();
        s_valid[1] = 1'b0;
        s_collect(acc, n, src);
        check("ovf_flushed_len", n, 1);
        check("ovf_flushed_rec", acc[31:0], 32'(HASH));
        check("ovf_flushed_src", src, 1);
        s_valid[0] = 1'b1; s_chari[0] = HASH;
        cycle();
        s_valid[0] = 1'b0;
        s_collect(acc, n, src);
        check("ovf_other_len", n, 4);
        check("ovf_other_rec", acc[31:0], 32'h5E616223);
        check("ovf_other_src", src, 0);
        check("ovf_sticky", 32'(s_ovf), 32'b0010);

        // Reset while the 5th character of a record is on chk_char.
        do_reset();
        rec = "^abcdefgh#";
        for (int k = 0; k < rec.len(); k++) begin
            vvalid[0] = 1'b1; vchar[0] = rec[k];
            cycle();
        end
        vvalid = '0;
        sab = "^zz#";
        for (int k = 0; k < 4; k++) begin
            vvalid[1] = 1'b1; vchar[1] = sab[k];
            cycle();
        end
        vvalid = '0;
        cycle();
        check("midrst_5th", 32'(chk_char), 32'(rec[4]));
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("midrst_chk", 32'(chk_char), 32'(IDLE));
        check("midrst_busy", 32'(busy), 0);
        check("midrst_ovf", 32'(ovf), 0);
        check("midrst_rv", 32'(res_valid), 0);
        check("midrst_ready", 32'(src_ready), 32'hF);
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            cycle();
            if (res_valid || chk_char != IDLE) seen++;
        end
        check("midrst_quiet", seen, 0);

        // Sources 0 and 2 refilled continuously.
        do_reset();
        for (int i = 0; i < N; i++) pc[i] = 0;
        for (int c = 0; c < 300; c++) begin
            logic [N-1:0] acc_w;
            for (int i = 0; i < N; i++) begin
                vvalid[i] = (i == 0 || i == 2);
                vchar[i]  = (pc[i] == 0) ? 8'h5E : (pc[i] == 7) ? HASH : 8'h61 + 8'(i);
                acc_w[i]  = vvalid[i] && (mq[i].size() < D);
            end
            cycle();
            for (int i = 0; i < N; i++) if (acc_w[i]) pc[i] = (pc[i] + 1) % 8;
        end
        vvalid = '0;
        check("pair_enough", 32'(grant_log.size() >= 10), 1);
        for (int k = 0; k < grant_log.size(); k++)
`ifdef TRACE_ARB_FIXED_PRIO_EN
            check($sformatf("pair_grant[%0d]", k), grant_log[k], 0);
`else
            check($sformatf("pair_grant[%0d]", k), grant_log[k], (k % 2 == 0) ? 0 : 2);
`endif

        // Randomized traffic against the model, with one reset in the middle.
        do_reset();
        for (int i = 0; i < N; i++) gen[i].delete();
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] acc_r;
            reset = (c == 1500);
            for (int i = 0; i < N; i++) begin
                if (gen[i].size() == 0) new_rec(i);
                vvalid[i] = ($urandom_range(0, 99) < 35);
                vchar[i]  = gen[i][0];
                acc_r[i]  = vvalid[i] && (mq[i].size() < D) && !reset;
            end
            fmt_in = 2'($urandom_range(0, 3));
            err_in = 4'($urandom_range(0, 15));
            cycle();
            for (int i = 0; i < N; i++) begin
                if (acc_r[i]) void'(gen[i].pop_front());
                if (reset) gen[i].delete();
            end
        end
        reset = 1'b0;
        vvalid = '0;
        for (int k = 0; k < 400; k++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
